calc_sched: RTL and testbench

CALC_SCHED -- requirements
Module: calc_sched

---
 rtl/calc_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_calc_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sched.sv
// calc_sched: a command FIFO feeding a three-state scheduler (IDLE/EXEC/WB)
// that drives an external combinational ALU and maintains a 16-bit
// accumulator.
//
// Build option: define CALC_SCHED_SAT_EN to enable signed saturation of the
// accumulator write-back and the sticky ovf flag. Without it the result is
// truncated to 16 bits and ovf is constant 0.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on FIFO occupancy and
// flush (never on cmd_valid or on a same-cycle pop), so a full FIFO refuses
// a command even in a cycle where an entry is being popped.
//
// dbg_state exposes the scheduler state (0 = IDLE, 1 = EXEC, 2 = WB).
module calc_sched #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [3:0]                    cmd_op,
   input  logic [15:0]                   cmd_data,
   input  logic                          cmd_clr,
   input  logic                          flush,
   output logic [3:0]                    alu_op,
   output logic [31:0]                   alu_a,
   output logic [31:0]                   alu_b,
   input  logic [31:0]                   alu_result,
   output logic [15:0]                   acc,
   output logic                          busy,
   output logic                          done,
   output logic                          zero_flag,
   output logic                          ovf,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [1:0]                    dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [3:0]    op_mem   [FIFO_DEPTH];
   logic [15:0]   data_mem [FIFO_DEPTH];
   logic          clr_mem  [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Scheduler state and in-flight command
   state_t        state_q, state_d;
   logic [3:0]    cur_op_q;
   logic [15:0]   cur_data_q;
   logic          cur_clr_q;
   logic [31:0]   res_q;
   logic [15:0]   acc_q, acc_d;

   logic          push;
   logic          pop;
   logic          fifo_empty;

   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = (count_q < DEPTH_C) && !flush;
   assign push       = cmd_valid && cmd_ready;
   // A flush discards every queued entry, including the head that would
   // otherwise be popped this cycle; only the command already in flight
   // survives.
   assign pop        = (state_q == IDLE) && !fifo_empty && !flush;

   // Write an accepted command into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr_q]   <= cmd_op;
         data_mem[wr_ptr_q] <= cmd_data;
         clr_mem[wr_ptr_q]  <= cmd_clr;
      end
   end

   // Next pointer/occupancy values; pointers wrap naturally at FIFO_DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Scheduler state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Scheduler next-state: one command takes exactly three cycles.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pop) state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Scheduler outputs: done marks the write-back cycle of each command.
   always_comb begin
      done = 1'b0;
      busy = 1'b0;
      unique case (state_q)
         IDLE:    busy = !fifo_empty;
         EXEC:    busy = 1'b1;
         WB:      begin busy = 1'b1; done = 1'b1; end
         default: busy = 1'b0;
      endcase
   end

   // Latch the head command when it leaves the FIFO; held until the next pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_op_q   <= '0;
         cur_data_q <= '0;
         cur_clr_q  <= 1'b0;
      end else if (pop) begin
         cur_op_q   <= op_mem[rd_ptr_q];
         cur_data_q <= data_mem[rd_ptr_q];
         cur_clr_q  <= clr_mem[rd_ptr_q];
      end
   end

   // Capture the ALU result in EXEC; a clear command forces a zero result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 res_q <= '0;
      else if (state_q == EXEC)   res_q <= cur_clr_q ? 32'd0 : alu_result;
   end

`ifdef CALC_SCHED_SAT_EN
   logic ovf_q, ovf_d;

   // Write-back with signed saturation; clear commands also reset ovf.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (state_q == WB) begin
         if (cur_clr_q) begin
            acc_d = '0;
            ovf_d = 1'b0;
         end else if ($signed(res_q) > 32'sd32767) begin
            acc_d = 16'h7FFF;
            ovf_d = 1'b1;
         end else if ($signed(res_q) < -32'sd32768) begin
            acc_d = 16'h8000;
            ovf_d = 1'b1;
         end else begin
            acc_d = res_q[15:0];
         end
      end
   end

   // Sticky overflow register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   // Without saturation the upper result bits carry no information.
   logic unused_res_hi;
   assign unused_res_hi = ^res_q[31:16];

   // Write-back by truncation; a clear command carries a zero result.
   always_comb begin
      acc_d = acc_q;
      if (state_q == WB) acc_d = res_q[15:0];
   end

   assign ovf = 1'b0;
`endif

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign alu_op     = cur_op_q;
   assign alu_a      = {{16{acc_q[15]}}, acc_q};
   assign alu_b      = {{16{cur_data_q[15]}}, cur_data_q};
   assign acc        = acc_q;
   assign zero_flag  = (acc_q == '0);
   assign fifo_count = count_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_calc_sched.sv
// Testbench for calc_sched: directed table of single commands, latency,
// burst/back-pressure, flush and asynchronous-reset sequences, then a
// randomized run against a queue-based reference model.
module tb_calc_sched;

   localparam int DEPTH = 4;
`ifdef CALC_SCHED_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [15:0] cmd_data = '0;
   logic        cmd_clr = 1'b0;
   logic        flush = 1'b0;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [15:0] acc;
   logic        busy, done, zero_flag, ovf;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [1:0]  dbg_state_unused;

   always #5 clk = ~clk;

   calc_sched #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_clr(cmd_clr), .flush(flush),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .acc(acc), .busy(busy), .done(done), .zero_flag(zero_flag), .ovf(ovf),
      .fifo_count(fifo_count), .dbg_state(dbg_state_unused)
   );

   // External ALU model: 2 = add, 6 = sub, anything else = xor.
   always_comb begin
      case (alu_op)
         4'h2:    alu_result = alu_a + alu_b;
         4'h6:    alu_result = alu_a - alu_b;
         default: alu_result = alu_a ^ alu_b;
      endcase
   end

   // ---------------- scoreboard bookkeeping ----------------
   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   logic [15:0] exp_q[$];

   always @(negedge clk) if (rst_n && done) done_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: plain integers, then clamp or wrap to 16 bits.
   function automatic void model_step(input logic [15:0] acc_in, input bit ovf_in,
                                      input logic [3:0] op, input logic [15:0] data,
                                      input bit clr, output logic [15:0] acc_out,
                                      output bit ovf_out);
      longint a, b, r;
      logic [31:0] x;
      a = longint'($signed(acc_in));
      b = longint'($signed(data));
      x = 32'(a) ^ 32'(b);
      if (clr) begin
         acc_out = '0;
         ovf_out = 1'b0;
         return;
      end
      case (op)
         4'h2:    r = a + b;
         4'h6:    r = a - b;
         default: r = longint'($signed(x));
      endcase
      ovf_out = SAT_ON ? ovf_in : 1'b0;
      if (SAT_ON && r > 32767) begin
         acc_out = 16'h7FFF; ovf_out = 1'b1;
      end else if (SAT_ON && r < -32768) begin
         acc_out = 16'h8000; ovf_out = 1'b1;
      end else begin
         acc_out = r[15:0];
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      cmd_valid = 1'b0; flush = 1'b0; cmd_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_ready_busy_zero", {cmd_ready, busy, zero_flag, done, ovf}, 5'b10100);
      check("rst_count", fifo_count, 0);
      check("rst_acc", acc, 0);
      check("rst_alu", {alu_op, alu_a, alu_b} == 68'd0, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Push one command (FSM idle, FIFO empty) and wait for its write-back.
   task automatic run_cmd(input logic [3:0] op, input logic [15:0] data,
                          input bit clr, output bit ok);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_clr = clr;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_clr = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (done) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (ok) begin @(posedge clk); #1; end
   endtask

   task automatic step(input bit v, input logic [3:0] op, input logic [15:0] d, input bit fl);
      cmd_valid = v; cmd_op = op; cmd_data = d; cmd_clr = 1'b0; flush = fl;
      @(posedge clk); #1;
      cmd_valid = 1'b0; flush = 1'b0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [3:0]  op;
      logic [15:0] data;
      bit          clr;
      logic [15:0] exp_acc;
      bit          exp_ovf;
   } vec_t;

   vec_t vecs[14];

   typedef struct {
      logic [3:0]  op;
      logic [15:0] data;
      bit          clr;
   } mcmd_t;

   logic [3:0]  bops[8] = '{4'h2, 4'h2, 4'h6, 4'h1, 4'h2, 4'h6, 4'h2, 4'h2};
   logic [15:0] bdat[8] = '{16'd1000, 16'd2000, 16'd500, 16'h00FF,
                            16'd7, 16'd3000, 16'd12, 16'd1};

   initial begin
      bit ok;
      bit saw_full;
      int base;
      logic [15:0] m_acc;
      bit m_ovf;
      mcmd_t m_q[$];
      mcmd_t m_cur;
      int m_timer;

      vecs[0]  = '{4'h2, 16'h0005, 1'b0, 16'h0005, 1'b0};
      vecs[1]  = '{4'h2, 16'hFFFD, 1'b0, 16'h0002, 1'b0};
      vecs[2]  = '{4'h6, 16'h000A, 1'b0, 16'hFFF8, 1'b0};
      vecs[3]  = '{4'h1, 16'h000F, 1'b0, 16'hFFF7, 1'b0};
      vecs[4]  = '{4'h0, 16'h1234, 1'b1, 16'h0000, 1'b0};
      vecs[5]  = '{4'h2, 16'h7FF0, 1'b0, 16'h7FF0, 1'b0};
      vecs[6]  = '{4'h2, 16'h0100, 1'b0, SAT_ON ? 16'h7FFF : 16'h80F0, SAT_ON};
      vecs[7]  = '{4'h0, 16'h0000, 1'b1, 16'h0000, 1'b0};
      vecs[8]  = '{4'h6, 16'h8000, 1'b0, SAT_ON ? 16'h7FFF : 16'h8000, SAT_ON};
      vecs[9]  = '{4'h6, 16'h7FFF, 1'b0, SAT_ON ? 16'h0000 : 16'h0001, SAT_ON};
      vecs[10] = '{4'h0, 16'h0000, 1'b1, 16'h0000, 1'b0};
      vecs[11] = '{4'h6, 16'h0001, 1'b0, 16'hFFFF, 1'b0};
      vecs[12] = '{4'h2, 16'h8000, 1'b0, SAT_ON ? 16'h8000 : 16'h7FFF, SAT_ON};
      vecs[13] = '{4'h0, 16'h0000, 1'b1, 16'h0000, 1'b0};

      // Latency of a single add after reset.
      do_reset();
      cmd_valid = 1'b1; cmd_op = 4'h2; cmd_data = 16'd5; cmd_clr = 1'b0;
      @(posedge clk); #1; cmd_valid = 1'b0;
      check("lat_e0_done", done, 0);
      check("lat_e0_count", fifo_count, 1);
      @(posedge clk); #1;
      check("lat_e1_done", done, 0);
      check("lat_e1_alu", {alu_op, alu_b}, {4'h2, 32'd5});
      @(posedge clk); #1;
      check("lat_e2_done", done, 1);
      check("lat_e2_acc", acc, 0);
      @(posedge clk); #1;
      check("lat_e3_done", done, 0);
      check("lat_e3_acc", {acc, zero_flag}, {16'd5, 1'b0});

      // Table of single commands.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         run_cmd(vecs[i].op, vecs[i].data, vecs[i].clr, ok);
         check("vec_done_seen", ok, 1);
         check("vec_acc", acc, vecs[i].exp_acc);
         check("vec_ovf", ovf, vecs[i].exp_ovf);
         check("vec_zero", zero_flag, vecs[i].exp_acc == 16'h0);
      end

      // Burst: 8 back-to-back commands, FIFO fills, in-order retirement.
      do_reset();
      m_acc = '0; m_ovf = 1'b0; saw_full = 1'b0;
      for (int k = 0; k < 8; k++) begin
         model_step(m_acc, m_ovf, bops[k], bdat[k], 1'b0, m_acc, m_ovf);
         exp_q.push_back(m_acc);
      end
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               int wn;
               wn = 0;
               cmd_valid = 1'b1; cmd_op = bops[k]; cmd_data = bdat[k]; cmd_clr = 1'b0;
               while (!cmd_ready && wn < 20) begin
                  saw_full = 1'b1;
                  @(posedge clk); #1; wn++;
               end
               @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
         end
         begin
            int cyc, got, last;
            bit prev_done;
            cyc = 0; got = 0; last = -1; prev_done = 1'b0;
            while (got < 8 && cyc < 80) begin
               @(posedge clk); #1; cyc++;
               if (prev_done && exp_q.size() > 0) check("burst_acc", acc, exp_q.pop_front());
               prev_done = done;
               if (done) begin
                  if (last >= 0) check("burst_done_gap", cyc - last, 3);
                  last = cyc; got++;
               end
            end
            if (prev_done && exp_q.size() > 0) begin
               @(posedge clk); #1;
               check("burst_acc", acc, exp_q.pop_front());
            end
            check("burst_retired", got, 8);
         end
      join
      check("burst_saw_full", saw_full, 1);

      // Flush while the first of three queued commands is executing.
      do_reset();
      base = done_cnt;
      step(1'b1, 4'h2, 16'd1, 1'b0);
      step(1'b1, 4'h2, 16'd10, 1'b0);
      step(1'b1, 4'h2, 16'd100, 1'b0);
      step(1'b1, 4'h2, 16'd1000, 1'b0);
      check("flush_pre_count", fifo_count, 3);
      step(1'b0, 4'h0, 16'd0, 1'b0);
      check("flush_exec_count", {busy, fifo_count}, {1'b1, 3'(2)});
      cmd_valid = 1'b1; cmd_data = 16'd5000; flush = 1'b1;
      #1;
      check("flush_ready_low", cmd_ready, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0; flush = 1'b0;
      check("flush_count", fifo_count, 0);
      repeat (15) begin @(posedge clk); #1; end
      check("flush_retired", done_cnt - base, 2);
      check("flush_acc", {acc, fifo_count}, {16'd11, 3'(0)});

      // Asynchronous reset in the middle of EXEC.
      do_reset();
      run_cmd(4'h2, 16'd7, 1'b0, ok);
      check("arst_pre_acc", acc, 7);
      base = done_cnt;
      step(1'b1, 4'h2, 16'd1, 1'b0);
      step(1'b1, 4'h2, 16'd2, 1'b0);
      check("arst_pre_count", {busy, fifo_count}, {1'b1, 3'(1)});
      #2 rst_n = 1'b0;
      #1;
      check("arst_acc", acc, 0);
      check("arst_count", fifo_count, 0);
      check("arst_flags", {done, busy, cmd_ready, zero_flag}, 4'b0011);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("arst_no_done", done_cnt - base, 0);
      check("arst_post_acc", acc, 0);

      // Randomized run against the queue model.
      do_reset();
      m_acc = '0; m_ovf = 1'b0; m_timer = 0;
      m_q.delete();
      for (int n = 0; n < 1500; n++) begin
         bit v, fl, rdy;
         mcmd_t c;
         check("rand_state", {acc, ovf, zero_flag, 8'(fifo_count), busy, done},
               {m_acc, m_ovf, m_acc == 16'h0, 8'(m_q.size()),
                (m_timer != 0) || (m_q.size() != 0), m_timer == 1});
         v  = ($urandom_range(99) < 60);
         fl = ($urandom_range(99) < 4);
         case ($urandom_range(3))
            0: c.op = 4'h2;
            1: c.op = 4'h6;
            2: c.op = 4'h1;
            default: c.op = 4'h3;
         endcase
         case ($urandom_range(5))
            0: c.data = 16'h7FFF;
            1: c.data = 16'h8000;
            2: c.data = 16'h0001;
            default: c.data = 16'($urandom);
         endcase
         c.clr = ($urandom_range(9) == 0);
         cmd_valid = v; cmd_op = c.op; cmd_data = c.data; cmd_clr = c.clr; flush = fl;
         #1;
         rdy = (m_q.size() < DEPTH) && !fl;
         check("rand_ready", cmd_ready, rdy);
         if (m_timer == 1) model_step(m_acc, m_ovf, m_cur.op, m_cur.data, m_cur.clr, m_acc, m_ovf);
         if (m_timer > 0) m_timer--;
         else if (m_q.size() > 0 && !fl) begin
            m_cur = m_q.pop_front();
            m_timer = 2;
         end
         if (fl) m_q.delete();
         else if (v && rdy) m_q.push_back(c);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0; flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
